// File: rtl/onehot_req_arbiter_pkg.sv
// Shared constants and FSM state encoding for the one-hot request arbiter.
package onehot_req_arbiter_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_req_arbiter_rr_pick.sv
// Round-robin picker: first set pending bit at or above ptr, wrapping 7->0.
// Purely combinational; pick is all-zero when pending is empty.
module onehot_req_arbiter_rr_pick
  import onehot_req_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] pending,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDXW-1:0] pick_idx
);

  logic [IDXW-1:0] idx;
  logic            found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    // idx is IDXW wide, so ptr + k wraps naturally past the top request
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDXW'(k);
      if (!found && pending[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/onehot_req_arbiter.sv
// Edge-detects req into a pending vector and issues one-hot round-robin grants.
// Rise-to-grant_valid is 2 cycles; a grant holds until grant_ack, so at most one grant per 2 cycles.
module onehot_req_arbiter
  import onehot_req_arbiter_pkg::*;
#(
  parameter int NREQ = onehot_req_arbiter_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  input  logic            grant_ack,
  output logic [NREQ-1:0] pending,
  output logic            overflow
);

  state_t          state_q, state_d;
  logic [NREQ-1:0] req_q, req_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] clear;
  logic [NREQ-1:0] pick;
  logic [IDXW-1:0] pick_idx;

  onehot_req_arbiter_rr_pick u_rr_pick (
    .pending  (pending_q),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    rise  = req & ~req_q;
    clear = '0;
    if (state_q == GRANT && grant_ack) begin
      clear = grant_q;
    end

    req_d = req;
    // a rise coinciding with its own clear re-arms the bit as a fresh event
    pending_d  = (pending_q & ~clear) | rise;
    overflow_d = overflow_q | (|(rise & pending_q & ~clear));

    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (en && (|pending_q)) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          grant_d = '0;
          ptr_d   = gidx_q + IDXW'(1);
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '1;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == GRANT);
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/onehot_req_arbiter.md
ONEHOT_REQ_ARBITER -- requirements
Module: onehot_req_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 8, meaning number of request lines; only 8 is supported, matching the 8-bit encoder input.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 8, meaning event request lines, where a rising edge on bit i means one event on source i.
REQ-005 The block SHALL have port en, input, 1, meaning arbitration enable.
REQ-006 The block SHALL have port grant, output, 8, meaning one-hot granted source; it drives the encoder din.
REQ-007 The block SHALL have port grant_valid, output, 1, meaning grant holds a valid one-hot value; it drives the encoder en.
REQ-008 The block SHALL have port grant_ack, input, 1, meaning the downstream consumer has taken the current grant.
REQ-009 The block SHALL have port pending, output, 8, meaning the registered pending-event vector.
REQ-010 The block SHALL have port overflow, output, 1, meaning sticky: an event was lost.

Function
REQ-011 The block SHALL register req into req_q each cycle and compute rise = req AND NOT req_q.
REQ-012 The block SHALL set pending[i] on the clock edge following a cycle with rise[i]=1.
REQ-013 The block SHALL clear pending[i] on the edge where grant_valid=1, grant_ack=1 and grant[i]=1.
REQ-014 The block SHALL keep pending[i] set when rise[i] and the ack-clear of bit i occur in the same cycle; this counts as a new event and SHALL NOT set overflow.
REQ-015 The block SHALL set overflow when rise[i]=1 while pending[i]=1 and bit i is not being cleared that cycle; overflow clears only on reset.
REQ-016 The block SHALL implement an FSM with two states, IDLE and GRANT.
REQ-017 In IDLE with en=1 and pending nonzero, the block SHALL choose the first set pending bit searching upward from ptr with wrap 7->0, register the chosen bit into grant, and move to GRANT.
REQ-018 In GRANT, the block SHALL assert grant_valid=1 and hold grant stable, regardless of en or new events, until grant_ack=1.
REQ-019 On ack in GRANT, the block SHALL set ptr to (granted index + 1) mod 8, wrapping index 7 to 0, and return to IDLE.
REQ-020 The block SHALL drive grant=8'h00 whenever grant_valid=0 and SHALL ignore grant_ack in IDLE.
REQ-021 Latency from a rise in cycle t to grant_valid=1 SHALL be 2 cycles when the FSM is idle; sustained throughput SHALL be at most one grant per 2 cycles.
REQ-022 With en=0 in IDLE, the block SHALL issue no grant; pending SHALL continue to accumulate.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 On rst=1, the block SHALL asynchronously set: state=IDLE, grant=8'h00, grant_valid=0, pending=8'h00, overflow=0, ptr=0, req_q=8'hFF.
REQ-025 Because req_q resets to 8'hFF, lines held high through reset release SHALL NOT generate events.
REQ-026 Reset asserted mid-GRANT SHALL drop grant_valid immediately and discard the outstanding grant and all pending events.

Structure
REQ-027 A shared package SHALL hold the NREQ constant and the FSM state enum (IDLE, GRANT).
REQ-028 The block SHALL contain one combinational sub-module, rr_pick (inputs pending and ptr; output one-hot pick and its index).

Verification
REQ-029 Reset release with req=8'h01 held, then no edges -> pending=8'h00 and grant_valid stays 0.
REQ-030 req bit 3 rises at cycle t with en=1 -> pending=8'h08 at t+1; grant=8'h08 and grant_valid=1 at t+2; ack -> pending=8'h00 and ptr=4.
REQ-031 pending=8'h81 with ptr=0 -> grants 8'h01 then 8'h80; after the second ack ptr wraps to 0.
REQ-032 Second rise on bit 5 while pending[5]=1 and unacked -> overflow=1, held until rst.
REQ-033 Rise on bit 2 in the same cycle as the ack of grant 8'h04 -> pending[2] stays 1, overflow=0, and a second grant of 8'h04 follows.
REQ-034 en=0 with pending=8'h10 -> no grant; en set to 1 -> grant=8'h10 one cycle later; rst asserted mid-GRANT -> grant_valid=0 in the same cycle.
